mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_pkg.sv | 39 +++
 rtl/mul_div_unit_iter_core.sv | 45 ++++
 rtl/mul_div_unit.sv | 134 +++++++++++++
 tb/tb_mul_div_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared CPU execute-stage definitions: ALU op codes, multiply/divide unit
// op codes, multiply/divide FSM states and the default iteration count.
package mul_div_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  // Codes 6 and 7 are reserved and ignored by the unit.
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  // One iteration per operand bit at the default word width.
  localparam int MDU_ITERS = 32;

endpackage

// File: rtl/mul_div_unit_iter_core.sv
// mdu_iter_core: one combinational step of the shared iterative datapath.
//   is_div   : 1 = restoring shift-subtract, 0 = radix-2 shift-add
//   acc      : partial product high half / partial remainder
//   mq       : multiplier (shifted out LSB first) / dividend-quotient
//   opb      : multiplicand / divisor magnitude
//   acc_next, mq_next : register values after this step
module mdu_iter_core #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  is_div,
  input  logic [WORD_WIDTH-1:0] acc,
  input  logic [WORD_WIDTH-1:0] mq,
  input  logic [WORD_WIDTH-1:0] opb,
  output logic [WORD_WIDTH-1:0] acc_next,
  output logic [WORD_WIDTH-1:0] mq_next
);

  logic [WORD_WIDTH:0] sum;
  logic [WORD_WIDTH:0] shifted;
  logic [WORD_WIDTH:0] diff;

  always_comb begin
    sum      = {1'b0, acc} + (mq[0] ? {1'b0, opb} : '0);
    shifted  = {acc, mq[WORD_WIDTH-1]};
    diff     = shifted - {1'b0, opb};
    acc_next = acc;
    mq_next  = mq;
    if (is_div) begin
      // Remainder stays below the divisor, so W+1 bits hold the trial value;
      // a set top bit means the subtraction went negative and is discarded.
      if (!diff[WORD_WIDTH]) begin
        acc_next = diff[WORD_WIDTH-1:0];
        mq_next  = {mq[WORD_WIDTH-2:0], 1'b1};
      end else begin
        acc_next = shifted[WORD_WIDTH-1:0];
        mq_next  = {mq[WORD_WIDTH-2:0], 1'b0};
      end
    end else begin
      // Carry out of the add becomes the new top bit of the product.
      acc_next = sum[WORD_WIDTH:1];
      mq_next  = {sum[0], mq[WORD_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS-style multiply/divide unit with HI/LO.
//   clk, rst_n : clock, synchronous active-low reset
//   start, op  : request strobe and op code (accepted only when idle)
//   src_a      : multiplicand / dividend / MTHI-MTLO data
//   src_b      : multiplier / divisor
//   busy       : iterative operation in progress (WORD_WIDTH+1 cycles)
//   hi, lo     : HI/LO registers, updated only when an operation completes
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WORD_WIDTH = MDU_ITERS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [WORD_WIDTH-1:0] src_a,
  input  logic [WORD_WIDTH-1:0] src_b,
  output logic                  busy,
  output logic [WORD_WIDTH-1:0] hi,
  output logic [WORD_WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WORD_WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_WIDTH - 1);

  function automatic logic [WORD_WIDTH-1:0] mag(input logic signed [WORD_WIDTH-1:0] x);
    return x[WORD_WIDTH-1] ? WORD_WIDTH'(-x) : x;
  endfunction

  mdu_state_e state, state_next;
  mdu_op_e    op_e;
  logic [CNT_W-1:0]      cnt;
  logic [WORD_WIDTH-1:0] acc, mq, opb;
  logic [WORD_WIDTH-1:0] acc_next, mq_next;
  logic                  is_div;
  logic                  neg_lo;   // negate product / quotient
  logic                  neg_hi;   // negate remainder (dividend sign)
  logic                  a_sign, b_sign, arith_op;
  logic [2*WORD_WIDTH-1:0] prod;

  assign op_e     = mdu_op_e'(op);
  assign a_sign   = src_a[WORD_WIDTH-1];
  assign b_sign   = src_b[WORD_WIDTH-1];
  assign arith_op = (op_e == MDU_MULT) || (op_e == MDU_MULTU) ||
                    (op_e == MDU_DIV)  || (op_e == MDU_DIVU);
  assign busy     = (state != ST_IDLE);
  assign prod     = neg_lo ? -{acc, mq} : {acc, mq};

  mdu_iter_core #(.WORD_WIDTH(WORD_WIDTH)) u_core (
    .is_div   (is_div),
    .acc      (acc),
    .mq       (mq),
    .opb      (opb),
    .acc_next (acc_next),
    .mq_next  (mq_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start && arith_op) state_next = ST_RUN;
      ST_RUN:  if (cnt == LAST)       state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      mq     <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (op_e)
              MDU_MTHI: hi <= src_a;
              MDU_MTLO: lo <= src_a;
              MDU_MULT, MDU_DIV: begin
                acc    <= '0;
                mq     <= mag(src_a);
                opb    <= mag(src_b);
                is_div <= (op_e == MDU_DIV);
                // Divide by zero must leave the all-ones quotient unnegated.
                neg_lo <= (a_sign ^ b_sign) && !((op_e == MDU_DIV) && (src_b == '0));
                neg_hi <= a_sign;
                cnt    <= '0;
              end
              MDU_MULTU, MDU_DIVU: begin
                acc    <= '0;
                mq     <= src_a;
                opb    <= src_b;
                is_div <= (op_e == MDU_DIVU);
                neg_lo <= 1'b0;
                neg_hi <= 1'b0;
                cnt    <= '0;
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          acc <= acc_next;
          mq  <= mq_next;
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
        ST_FIX: begin
          if (is_div) begin
            lo <= neg_lo ? -mq  : mq;
            hi <= neg_hi ? -acc : acc;
          end else begin
            hi <= prod[2*WORD_WIDTH-1:WORD_WIDTH];
            lo <= prod[WORD_WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and randomized self-checking bench for mul_div_unit (WORD_WIDTH=32).
module tb_mul_div_unit;

  localparam int W = 32;
  localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2,
                         OP_DIVU = 3'd3, OP_MTHI = 3'd4, OP_MTLO = 3'd5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy;
  logic [W-1:0] hi, lo;

  int n_pass = 0;
  int n_total = 0;

  mul_div_unit #(.WORD_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for exactly one edge, then scrambles operands.
  task automatic start_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    step();
    start = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
  endtask

  // Counts samples with busy high; also notes any hi/lo change while busy.
  task automatic wait_idle(input logic [W-1:0] ph, input logic [W-1:0] pl,
                           output int cycles, output logic held);
    cycles = 0;
    held   = 1'b1;
    while (busy && cycles < 100) begin
      cycles = cycles + 1;
      if (hi !== ph || lo !== pl) held = 1'b0;
      step();
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    logic [W-1:0] ph, pl;
    int cycles;
    logic held;
    ph = hi;
    pl = lo;
    start_op(o, a, b);
    wait_idle(ph, pl, cycles, held);
    check({tag, " latency"}, 64'(cycles), 64'(W + 1));
    check({tag, " hold"}, 64'(held), 64'd1);
    check({tag, " hi"}, 64'(hi), 64'(eh));
    check({tag, " lo"}, 64'(lo), 64'(el));
  endtask

  task automatic ref_model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] eh, output logic [W-1:0] el);
    logic [63:0] p;
    longint q, r;
    case (o)
      OP_MULT:  p = 64'(longint'($signed(a)) * longint'($signed(b)));
      OP_MULTU: p = {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == '0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == '0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    eh = p[63:32];
    el = p[31:0];
  endtask

  initial begin
    int cycles;
    logic held;
    logic [2:0] o;
    logic [W-1:0] a, b, eh, el;

    // Reset state
    repeat (2) step();
    check("reset busy", 64'(busy), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    step();

    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_by0", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    run_op("div_m7_by0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);

    // MTHI then MTLO on consecutive edges
    start = 1'b1; op = OP_MTHI; src_a = 32'h1234_5678;
    step();
    check("mthi hi", 64'(hi), 64'h1234_5678);
    check("mthi busy", 64'(busy), 64'd0);
    op = OP_MTLO; src_a = 32'hCAFE_BABE;
    step();
    start = 1'b0;
    check("mtlo lo", 64'(lo), 64'hCAFE_BABE);
    check("mtlo hi", 64'(hi), 64'h1234_5678);
    check("mtlo busy", 64'(busy), 64'd0);

    // Reserved op code is ignored
    start = 1'b1; op = 3'd6; src_a = 32'h1111_1111;
    step();
    start = 1'b0;
    check("rsv busy", 64'(busy), 64'd0);
    check("rsv hi", 64'(hi), 64'h1234_5678);
    check("rsv lo", 64'(lo), 64'hCAFE_BABE);

    // MTLO pulsed while a DIVU runs is dropped
    start_op(OP_DIVU, 32'd1000, 32'd7);
    repeat (4) step();
    start = 1'b1; op = OP_MTLO; src_a = 32'hDEAD_BEEF;
    step();
    start = 1'b0;
    wait_idle(32'h1234_5678, 32'hCAFE_BABE, cycles, held);
    check("busy_mtlo latency", 64'(cycles + 5), 64'(W + 1));
    check("busy_mtlo hold", 64'(held), 64'd1);
    check("busy_mtlo hi", 64'(hi), 64'd6);
    check("busy_mtlo lo", 64'(lo), 64'd142);

    // Reset during MULT aborts; start in the reset cycle is ignored
    start_op(OP_MULT, 32'd5, 32'd9);
    repeat (9) step();
    rst_n = 1'b0;
    start = 1'b1; op = OP_MTHI; src_a = 32'h5555_5555;
    step();
    start = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    run_op("post_rst_multu", OP_MULTU, 32'd7, 32'd6, 32'd0, 32'd42);

    // Randomized operations against the reference model
    for (int i = 0; i < 1000; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = '0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'($urandom_range(1, 17));
        default: ;
      endcase
      ref_model(o, a, b, eh, el);
      run_op($sformatf("rand%0d op%0d", i, o), o, a, b, eh, el);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
